// File: rtl/axi4_lite_slave_pkg.sv
// Shared defaults and FSM state types for the AXI4-Lite slave memory.
package axi4_lite_slave_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_MEM_WORDS  = 64;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axi4_lite_slave_mem_if.sv
// AXI4-Lite bus bundle (no response-code signals) with master/slave views.
interface axi4_lite_slave_mem_if
    import axi4_lite_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
    );

endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// Word array with one byte-strobed write port and one registered read port.
// AXIL_MEM_CLEAR_EN: reset also zeroes every word (otherwise only the read register resets).
module axi4_lite_slave_regfile
    import axi4_lite_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned MEM_WORDS  = DEFAULT_MEM_WORDS,
    localparam int unsigned IDX_WIDTH  = $clog2(MEM_WORDS),
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  re,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

`ifdef AXIL_MEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < MEM_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (we) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end
`endif

    // Non-blocking write above means a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave memory: independent write/read FSMs around a byte-writable regfile.
// AXIL_MEM_CLEAR_EN selects whether reset also clears the memory contents.
module axi4_lite_slave_mem
    import axi4_lite_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned MEM_WORDS  = DEFAULT_MEM_WORDS
) (
    input  logic ACLK,
    input  logic ARESETn,
    axi4_lite_slave_mem_if.slave bus
);

    localparam int unsigned IDX_WIDTH  = $clog2(MEM_WORDS);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic                  ready_en;
    logic                  aw_held, w_held;
    logic [IDX_WIDTH-1:0]  aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic                  aw_fire, w_fire, ar_fire, commit;
    logic                  mem_we, mem_re;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  addr_unused;

    // ready_en keeps all READYs low on the reset edge and raises them one edge later.
    assign bus.AWREADY = ready_en && (wr_state == W_IDLE) && !aw_held;
    assign bus.WREADY  = ready_en && (wr_state == W_IDLE) && !w_held;
    assign bus.ARREADY = ready_en && (rd_state == R_IDLE);
    assign bus.BVALID  = (wr_state == W_RESP);
    assign bus.RVALID  = (rd_state == R_DATA);

    assign aw_fire = bus.AWVALID && bus.AWREADY;
    assign w_fire  = bus.WVALID  && bus.WREADY;
    assign ar_fire = bus.ARVALID && bus.ARREADY;

    assign addr_unused = ^{bus.AWADDR[ADDR_WIDTH-1:IDX_WIDTH+2], bus.AWADDR[1:0],
                           bus.ARADDR[ADDR_WIDTH-1:IDX_WIDTH+2], bus.ARADDR[1:0]};

    always_comb begin
        wr_state_nxt = wr_state;
        commit       = 1'b0;
        wr_idx       = aw_held ? aw_idx_q : bus.AWADDR[IDX_WIDTH+1:2];
        wr_data      = w_held  ? w_data_q : bus.WDATA;
        wr_strb      = w_held  ? w_strb_q : bus.WSTRB;
        case (wr_state)
            W_IDLE: begin
                if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                    commit       = 1'b1;
                    wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.BREADY) wr_state_nxt = W_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE: if (ar_fire) rd_state_nxt = R_DATA;
            R_DATA: if (bus.RREADY) rd_state_nxt = R_IDLE;
        endcase
    end

    assign mem_we = commit  && !ARESETn;
    assign mem_re = ar_fire && !ARESETn;

    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            ready_en <= 1'b0;
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            ready_en <= 1'b1;
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= bus.AWADDR[IDX_WIDTH+1:2];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= bus.WDATA;
                    w_strb_q <= bus.WSTRB;
                end
            end
        end
    end

    axi4_lite_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_regfile (
        .clk   (ACLK),
        .rst   (ARESETn),
        .we    (mem_we),
        .waddr (wr_idx),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .re    (mem_re),
        .raddr (bus.ARADDR[IDX_WIDTH+1:2]),
        .rdata (bus.RDATA)
    );

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Scoreboard bench for axi4_lite_slave_mem: directed cases then randomized traffic
// checked against a byte-level memory model; honours AXIL_MEM_CLEAR_EN.
module tb_axi4_lite_slave_mem;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    axi4_lite_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_slave_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_WORDS  (64)
    ) dut (
        .ACLK    (aclk),
        .ARESETn (aresetn),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
    } rexp_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] model [64];
    logic [3:0]  known [64];
    rexp_t       r_q [$];
    int unsigned b_q [$];
    rexp_t       mon_e;
    logic [31:0] rdata_prev;
    bit          rhold = 0;
    bit          rnd_ready = 0;
    logic        bready_fix = 1'b1;
    logic        rready_fix = 1'b1;

    function automatic int unsigned widx(input logic [31:0] a);
        return {26'd0, a[7:2]};
    endfunction

    function automatic logic [31:0] mask32(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input logic [31:0] mask);
        n_vec++;
        if (((act ^ exp) & mask) !== 32'h0) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (mask %08h) at %0t", name, act, exp, mask, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
`ifdef AXIL_MEM_CLEAR_EN
            model[i] = 32'h0;
            known[i] = 4'hF;
`else
            model[i] = 32'h0;
            known[i] = 4'h0;
`endif
        end
    endtask

    always @(posedge aclk) begin
        #1;
        if (rnd_ready) begin
            bus.BREADY = ($urandom_range(3) != 0);
            bus.RREADY = ($urandom_range(3) != 0);
        end else begin
            bus.BREADY = bready_fix;
            bus.RREADY = rready_fix;
        end
    end

    // Monitor: pops expectations whenever the DUT completes a B or R beat.
    always @(negedge aclk) begin
        if (aresetn !== 1'b0) begin
            rhold = 0;
        end else begin
            if (bus.BVALID && bus.BREADY) begin
                check("b_expected", {31'd0, b_q.size() != 0}, 32'd1, 32'd1);
                if (b_q.size() != 0) void'(b_q.pop_front());
            end
            if (bus.RVALID) begin
                if (rhold) check("rdata_stable", bus.RDATA, rdata_prev, 32'hFFFF_FFFF);
                if (bus.RREADY) begin
                    if (r_q.size() == 0) begin
                        check("r_expected", 32'd0, 32'd1, 32'd1);
                    end else begin
                        mon_e = r_q.pop_front();
                        check("rdata", bus.RDATA, mon_e.data, mon_e.mask);
                    end
                    rhold = 0;
                end else begin
                    rhold      = 1;
                    rdata_prev = bus.RDATA;
                end
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int unsigned w_lag);
        bit aw_done = 0, w_done = 0, aw_hs = 0, w_hs = 0, timed_out = 0;
        int unsigned cyc = 0;
        forever begin
            @(posedge aclk);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            #1;
            if (aw_done && w_done) break;
            if (cyc > 100) begin
                timed_out = 1;
                break;
            end
            bus.AWVALID = !aw_done;
            bus.AWADDR  = addr;
            bus.WVALID  = !w_done && (cyc >= w_lag);
            bus.WDATA   = data;
            bus.WSTRB   = strb;
            @(negedge aclk);
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            if (aw_done && !w_done) check("awready_while_w_pending", {31'd0, bus.AWREADY}, 32'd0, 32'd1);
            cyc++;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        if (timed_out) begin
            n_vec++;
            n_err++;
            $display("FAIL write_timeout: addr %08h not accepted, required within 100 cycles", addr);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                model[widx(addr)][8*i +: 8] = data[8*i +: 8];
                known[widx(addr)][i]        = 1'b1;
            end
        end
        b_q.push_back(1);
        @(negedge aclk);
        check("bvalid_latency", {31'd0, bus.BVALID}, 32'd1, 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr);
        bit hs = 0, timed_out = 0;
        int unsigned cyc = 0;
        rexp_t e;
        forever begin
            @(posedge aclk);
            #1;
            if (hs) break;
            if (cyc > 100) begin
                timed_out = 1;
                break;
            end
            bus.ARVALID = 1'b1;
            bus.ARADDR  = addr;
            @(negedge aclk);
            hs = bus.ARVALID && bus.ARREADY;
            if (hs) begin
                e.data = model[widx(addr)];
                e.mask = mask32(known[widx(addr)]);
                r_q.push_back(e);
            end
            cyc++;
        end
        bus.ARVALID = 1'b0;
        if (timed_out) begin
            n_vec++;
            n_err++;
            $display("FAIL read_timeout: addr %08h not accepted, required within 100 cycles", addr);
            return;
        end
        @(negedge aclk);
        check("rvalid_latency", {31'd0, bus.RVALID}, 32'd1, 32'd1);
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        aresetn     = 1'b1;
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        bus.ARVALID = 1'b0;
        bus.AWADDR  = '0;
        bus.WDATA   = '0;
        bus.WSTRB   = '0;
        bus.ARADDR  = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", {31'd0, bus.AWREADY}, 32'd0, 32'd1);
        check("rst_wready",  {31'd0, bus.WREADY},  32'd0, 32'd1);
        check("rst_arready", {31'd0, bus.ARREADY}, 32'd0, 32'd1);
        check("rst_bvalid",  {31'd0, bus.BVALID},  32'd0, 32'd1);
        check("rst_rvalid",  {31'd0, bus.RVALID},  32'd0, 32'd1);
        check("rst_rdata",   bus.RDATA, 32'd0, 32'hFFFF_FFFF);
        @(posedge aclk);
        #1 aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("post_rst_ready", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd7, 32'd7);

        // Directed cases
        axi_read(32'h10);
        axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0);
        axi_read(32'h04);
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(32'h08, 32'h1234_5678, 4'h5, 0);
        axi_read(32'h08);
        axi_write(32'h0C, 32'hCAFE_F00D, 4'hF, 3);
        axi_read(32'h0C);

        bready_fix = 1'b0;
        axi_write(32'h14, 32'h1111_2222, 4'hF, 0);
        fork
            begin
                repeat (5) begin
                    @(negedge aclk);
                    check("stall_bvalid",  {31'd0, bus.BVALID},  32'd1, 32'd1);
                    check("stall_awready", {31'd0, bus.AWREADY}, 32'd0, 32'd1);
                    check("stall_wready",  {31'd0, bus.WREADY},  32'd0, 32'd1);
                end
            end
            begin
                axi_read(32'h04);
            end
        join
        bready_fix = 1'b1;
        repeat (3) @(posedge aclk);

        axi_write(32'h100, 32'hA5A5_A5A5, 4'hF, 0);
        axi_read(32'h000);

        bready_fix = 1'b0;
        axi_write(32'h20, 32'h5555_AAAA, 4'hF, 1);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("rst_mid_bvalid", {31'd0, bus.BVALID}, 32'd0, 32'd1);
        b_q.delete();
        r_q.delete();
`ifdef AXIL_MEM_CLEAR_EN
        model_reset();
`endif
        bready_fix = 1'b1;
        @(posedge aclk);
        #1 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        axi_read(32'h20);

        // Randomized traffic with random BREADY/RREADY back-pressure
        rnd_ready = 1;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = {22'd0, 8'($urandom_range(255)), 2'($urandom_range(3))};
            if ($urandom_range(1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(15)), $urandom_range(3));
            else
                axi_read(a);
        end
        rnd_ready = 0;
        for (int i = 0; i < 50 && (b_q.size() != 0 || r_q.size() != 0); i++) @(posedge aclk);
        @(negedge aclk);
        check("drain_b", b_q.size(), 32'd0, 32'hFFFF_FFFF);
        check("drain_r", r_q.size(), 32'd0, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_mem.md
# axi4_lite_slave_mem

AXI4-Lite slave holding a word-addressed, byte-writable memory. It is the target of the AXI4-Lite verification environment: write and read channels are serviced independently, one outstanding transaction per direction. There are no response-code ports; every access completes as OKAY.

## Interface
Parameters:
- ADDR_WIDTH, 32: AWADDR/ARADDR width.
- DATA_WIDTH, 32: WDATA/RDATA width. WSTRB is DATA_WIDTH/8 bits.
- MEM_WORDS, 64: memory depth in words. Must be a power of two.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset; synchronous, active-high despite the codebase name.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_WIDTH  read data.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

## Operation
- Word index is addr[log2(MEM_WORDS)+1 : 2].
- Address bits [1:0] are ignored.
- Address bits above the index are ignored, so addresses alias and wrap.

Write FSM, states W_IDLE, W_RESP:
- In W_IDLE, the AW and W channels are captured independently. AWREADY=1 until the address is latched; WREADY=1 until the data and strobe are latched.
- When both are held (same cycle or different cycles), memory is updated byte-by-byte where WSTRB[i]=1, BVALID rises, and the FSM moves to W_RESP.
- In W_RESP, AWREADY=WREADY=0. BVALID holds until BVALID&&BREADY, then the FSM returns to W_IDLE.

Read FSM, states R_IDLE, R_DATA:
- In R_IDLE, ARREADY=1. On ARVALID&&ARREADY, the addressed word is loaded into RDATA, RVALID rises, and the FSM moves to R_DATA.
- In R_DATA, ARREADY=0. RDATA and RVALID hold until RREADY, then the FSM returns to R_IDLE.

Collision rules:
- A read captured on the same edge as a write commit to the same word returns the old data.
- Reads and writes never stall each other.

## Timing
Reset, while ARESETn=1 at a clock edge:
- AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, RDATA=0.
- Both FSMs go to idle and latched AW/W are discarded.

After reset:
- The first edge after ARESETn falls sets all three READY signals to 1.
- Reset asserted mid-transaction abandons it; the write memory update only occurs if commit happened before reset.

Latencies:
- AW and W handshaken in the same cycle: BVALID=1 on the next cycle.
- AW and W handshaken separately: BVALID=1 on the cycle after the later handshake.
- AR handshake: RVALID=1 with RDATA on the next cycle.
- Minimum throughput: one write per 2 cycles and one read per 2 cycles (BREADY/RREADY tied high).

Handshake rules:
- VALID outputs never drop without the handshake.
- RDATA is stable while RVALID=1.

## Configuration
- AXIL_MEM_CLEAR_EN defined: reset also clears every memory word to 0, so an unwritten read returns 0.
- AXIL_MEM_CLEAR_EN undefined: memory is not reset, which allows RAM inference; an unwritten read returns an undefined value. Only the control state is reset.

## Structure
- Package axi4_lite_slave_pkg holds:
  - the default widths and MEM_WORDS;
  - the write FSM enum {W_IDLE, W_RESP};
  - the read FSM enum {R_IDLE, R_DATA}.
- Sub-module axi4_lite_slave_regfile: MEM_WORDS×DATA_WIDTH array with one byte-strobed write port and one synchronous read port. The top holds both FSMs and the handshake registers.

## Test plan
1. Reset, then read 0x10 with AXIL_MEM_CLEAR_EN defined -> RDATA=0x00000000; all READY signals 0 during reset and 1 one cycle after it.
2. Write 0x04 data 0xDEADBEEF WSTRB=0xF (AW and W in the same cycle) -> BVALID next cycle. Then read 0x04 -> 0xDEADBEEF, RVALID one cycle after AR.
3. Write 0x08 0xFFFFFFFF, then write 0x08 0x12345678 WSTRB=0x5 -> read 0x08 = 0xFF34FF78.
4. AW at 0x0C first, W 0xCAFEF00D three cycles later -> AWREADY=0 while waiting; BVALID one cycle after the W handshake; read 0x0C = 0xCAFEF00D.
5. BREADY held low for 5 cycles -> BVALID stays 1 and AWREADY/WREADY stay 0. Meanwhile a read of 0x04 completes normally.
6. Alias check (MEM_WORDS=64): write 0x100 with 0xA5A5A5A5 -> read 0x000 = 0xA5A5A5A5. Separately, reset asserted while BVALID=1 -> BVALID=0 on the next edge.
